// File: rtl/sec_countdown_if.sv
// Signal bundle between the traffic-light controller and the seconds countdown.
interface sec_countdown_if #(
    parameter int MAX_SEC = 99
);
    localparam int W = $clog2(MAX_SEC + 1);

    logic         slow_in;
    logic         load;
    logic [W-1:0] load_val;
    logic         pause;
    logic         sec_tick;
    logic [W-1:0] remaining;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic         busy;
    logic         done;

    modport master (
        output slow_in, load, load_val, pause,
        input  sec_tick, remaining, tens, ones, busy, done
    );

    modport slave (
        input  slow_in, load, load_val, pause,
        output sec_tick, remaining, tens, ones, busy, done
    );
endinterface

// File: rtl/sec_countdown.sv
// Seconds countdown: synchronises the 1 Hz divider wave, derives a one-cycle
// tick from each rising edge and counts a loaded duration down to zero.
module sec_countdown #(
    parameter int MAX_SEC = 99
) (
    input logic          clk_50MHz,
    input logic          res,
    sec_countdown_if.slave bus
);
    localparam int W = $clog2(MAX_SEC + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t       state;
    logic         s1, s2, s3;
    logic         tick_q;
    logic [W-1:0] rem_q;
    logic         busy_q;
    logic         done_q;
    logic [W-1:0] ld_val;

    assign ld_val = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk_50MHz or negedge res) begin
        if (!res) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            tick_q <= 1'b0;
            state  <= IDLE;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            s1     <= bus.slow_in;
            s2     <= s1;
            s3     <= s2;
            tick_q <= s2 & ~s3;
            done_q <= 1'b0;

            if (bus.load) begin
                rem_q <= ld_val;
                if (ld_val == '0) begin
                    state  <= EXPIRE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    state  <= RUN;
                    busy_q <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    RUN: begin
                        if (tick_q && !bus.pause) begin
                            if (rem_q <= W'(1)) begin
                                rem_q  <= '0;
                                state  <= EXPIRE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                rem_q <= rem_q - W'(1);
                            end
                        end
                    end
                    EXPIRE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sec_tick  = tick_q;
    assign bus.remaining = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.tens      = 4'(rem_q / W'(10));
    assign bus.ones      = 4'(rem_q % W'(10));
endmodule
